// File: rtl/pipearch_common.sv
`default_nettype none
// ============================================================================
//  Module      : pipearch_common (package)
//  Description : Shared CSR write-strobe and command types for the pipeline
//                architecture blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipearch_common;

    // Operand slots carried by every command (CSR indices 1..CSR_NUM_ARGS)
    localparam int          CSR_NUM_ARGS     = 3;
    // CSR index that acts as the doorbell
    localparam int          CSR_DOORBELL_IDX = 0;
    // Doorbell opcode that flushes the receiver instead of queueing a command
    localparam logic [15:0] OPC_FLUSH        = 16'hFFFF;

    // Per-CSR write strobe from the CPU side
    typedef struct packed {
        logic        en;
        logic [63:0] data;
    } t_cpu_wr_csrs;

    // Command handed to the consumer; args[0] holds operand CSR 1
    typedef struct packed {
        logic [15:0]                        opcode;
        logic [15:0]                        seq;
        logic [CSR_NUM_ARGS-1:0][63:0]      args;
    } t_csr_cmd;

endpackage
`default_nettype wire

// File: rtl/csr_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : csr_cmd_fifo
//  Description : Synchronous show-ahead FIFO of t_csr_cmd entries with
//                occupancy count, full and empty flags and a clear input.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_cmd_fifo
    import pipearch_common::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  t_csr_cmd              wr_data,
    input  logic                  pop,
    output t_csr_cmd              rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    t_csr_cmd                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // A full FIFO may still take a push when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head entry is shown ahead; zero when nothing is queued
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clear empties the queue outright
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the output is gated by empty
    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_cmd_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : csr_cmd_receiver
//  Description : Collects operand CSR writes, turns doorbell writes into
//                sequenced commands and queues them for a ready/valid consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_cmd_receiver
    import pipearch_common::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int NUM_ARGS        = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  t_cpu_wr_csrs [NUM_ARGS:0]   wr_csrs,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output t_csr_cmd                    cmd,
    output logic [FIFO_DEPTH_LOG2:0]    cmd_count,
    output logic                        err_missing_arg,
    output logic                        err_overflow
);

    logic [NUM_ARGS-1:0]         present_q, present_d, present_now;
    logic [NUM_ARGS-1:0][63:0]   arg_q, arg_d;
    logic [15:0]                 seq_q, seq_d;
    logic                        err_miss_q, err_miss_d;
    logic                        err_ovf_q, err_ovf_d;

    logic                        doorbell;
    logic [15:0]                 opcode;
    logic [NUM_ARGS-1:0]         required;
    logic                        is_flush;
    logic                        missing;
    logic                        can_accept;
    logic                        push;
    logic                        pop;
    logic                        overflow;
    t_csr_cmd                    push_cmd;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        doorbell_data_unused;

    assign doorbell_data_unused = ^wr_csrs[CSR_DOORBELL_IDX].data[63:16+NUM_ARGS];

    assign doorbell   = wr_csrs[CSR_DOORBELL_IDX].en;
    assign opcode     = wr_csrs[CSR_DOORBELL_IDX].data[15:0];
    assign required   = wr_csrs[CSR_DOORBELL_IDX].data[16 +: NUM_ARGS];
    assign is_flush   = doorbell && (opcode == OPC_FLUSH);
    assign pop        = cmd_valid && cmd_ready;
    assign can_accept = !fifo_full || pop;
    // Missing operands take precedence over a full queue when reporting errors
    assign missing    = doorbell && !is_flush && ((required & ~present_now) != '0);
    assign push       = doorbell && !is_flush && !missing && can_accept;
    assign overflow   = doorbell && !is_flush && !missing && !can_accept;

    // Operand capture with same-cycle bypass into the doorbell snapshot
    always_comb begin
        present_now = present_q;
        arg_d       = arg_q;
        push_cmd    = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (wr_csrs[i+1].en) begin
                present_now[i] = 1'b1;
                arg_d[i]       = wr_csrs[i+1].data;
            end
        end
        push_cmd.opcode = opcode;
        push_cmd.seq    = seq_q;
        for (int i = 0; i < NUM_ARGS; i++) begin
            push_cmd.args[i] = arg_d[i];
        end
    end

    // Next-state for presence bits, sequence number and sticky error flags
    always_comb begin
        present_d  = (push || is_flush) ? '0 : present_now;
        seq_d      = push ? seq_q + 16'd1 : seq_q;
        err_miss_d = is_flush ? 1'b0 : (err_miss_q || missing);
        err_ovf_d  = is_flush ? 1'b0 : (err_ovf_q || overflow);
    end

    // Receiver state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            present_q  <= '0;
            arg_q      <= '0;
            seq_q      <= '0;
            err_miss_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            present_q  <= present_d;
            arg_q      <= arg_d;
            seq_q      <= seq_d;
            err_miss_q <= err_miss_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    csr_cmd_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (is_flush),
        .push    (push),
        .wr_data (push_cmd),
        .pop     (pop),
        .rd_data (cmd),
        .count   (cmd_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_valid       = !fifo_empty;
    assign err_missing_arg = err_miss_q;
    assign err_overflow    = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_cmd_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_cmd_receiver
//  Description : Self-checking bench for csr_cmd_receiver with a queue-level
//                reference model and directed plus randomized scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_cmd_receiver;
    import pipearch_common::*;

    logic                clk = 1'b0;
    logic                reset;
    t_cpu_wr_csrs [3:0]  wr_csrs;
    logic                cmd_valid;
    logic                cmd_ready;
    t_csr_cmd            cmd;
    logic [2:0]          cmd_count;
    logic                err_missing_arg;
    logic                err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    t_csr_cmd    m_q[$];
    logic [2:0]  m_present;
    logic [63:0] m_args [3];
    logic [15:0] m_seq;
    logic        m_errm;
    logic        m_erro;

    csr_cmd_receiver #(
        .FIFO_DEPTH_LOG2 (2),
        .NUM_ARGS        (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_csrs         (wr_csrs),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd             (cmd),
        .cmd_count       (cmd_count),
        .err_missing_arg (err_missing_arg),
        .err_overflow    (err_overflow)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs presented at the edge
    task automatic model_step();
        bit       pop_now;
        bit       can;
        bit       do_push;
        t_csr_cmd c;
        logic [15:0] op;
        logic [2:0]  req;
        c = '0;
        do_push = 0;
        if (reset) begin
            m_q.delete();
            m_present = '0;
            foreach (m_args[i]) m_args[i] = '0;
            m_seq = '0; m_errm = 0; m_erro = 0;
            return;
        end
        pop_now = (m_q.size() != 0) && cmd_ready;
        can     = (m_q.size() < 4) || pop_now;
        for (int i = 0; i < 3; i++) begin
            if (wr_csrs[i+1].en) begin
                m_args[i]    = wr_csrs[i+1].data;
                m_present[i] = 1'b1;
            end
        end
        if (wr_csrs[0].en) begin
            op  = wr_csrs[0].data[15:0];
            req = wr_csrs[0].data[18:16];
            if (op == 16'hFFFF) begin
                m_q.delete();
                m_present = '0;
                m_errm = 0; m_erro = 0;
                return;
            end else if ((req & ~m_present) != 3'b000) begin
                m_errm = 1;
            end else if (!can) begin
                m_erro = 1;
            end else begin
                c.opcode = op;
                c.seq    = m_seq;
                for (int i = 0; i < 3; i++) c.args[i] = m_args[i];
                do_push  = 1;
                m_seq    = m_seq + 16'd1;
                m_present = '0;
            end
        end
        if (pop_now) void'(m_q.pop_front());
        if (do_push) m_q.push_back(c);
    endtask

    // One clock: model follows the edge, outputs settle, write strobes drop
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 4; i++) wr_csrs[i].en = 1'b0;
    endtask

    task automatic wr_op(input int idx, input logic [63:0] data);
        wr_csrs[idx].en   = 1'b1;
        wr_csrs[idx].data = data;
    endtask

    task automatic ring(input logic [63:0] data);
        wr_csrs[0].en   = 1'b1;
        wr_csrs[0].data = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_ready = 1'b1;
        wr_op(1, 64'h1234);
        ring(64'h0000_0000_0000_0001);
        tick();
        tick();
        n_checks++; if (cmd_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
        n_checks++; if (cmd !== '0)          begin n_errors++; $display("FAIL reset_cmd got=%h exp=0", cmd); end
        n_checks++; if (cmd_count !== 3'd0)  begin n_errors++; $display("FAIL reset_count got=%0d exp=0", cmd_count); end
        n_checks++; if ({err_missing_arg, err_overflow} !== 2'b00)
            begin n_errors++; $display("FAIL reset_errs got=%b%b exp=00", err_missing_arg, err_overflow); end
        reset = 1'b0;
        cmd_ready = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        wr_op(1, 64'hA); tick();
        wr_op(2, 64'hB); tick();
        ring(64'h0003_0005); tick();
        n_checks++; if (cmd_valid !== 1'b1)       begin n_errors++; $display("FAIL basic_valid got=%b exp=1", cmd_valid); end
        n_checks++; if (cmd.opcode !== 16'd5)     begin n_errors++; $display("FAIL basic_opcode got=%h exp=5", cmd.opcode); end
        n_checks++; if (cmd.seq !== 16'd0)        begin n_errors++; $display("FAIL basic_seq got=%h exp=0", cmd.seq); end
        n_checks++; if (cmd.args[0] !== 64'hA || cmd.args[1] !== 64'hB)
            begin n_errors++; $display("FAIL basic_args got=%h,%h exp=a,b", cmd.args[0], cmd.args[1]); end
        n_checks++; if (cmd_count !== 3'd1)       begin n_errors++; $display("FAIL basic_count got=%0d exp=1", cmd_count); end
        cmd_ready = 1'b1; tick();
        n_checks++; if (cmd_valid !== 1'b0 || cmd_count !== 3'd0)
            begin n_errors++; $display("FAIL basic_drain got=%b/%0d exp=0/0", cmd_valid, cmd_count); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_missing();
        do_reset();
        ring(64'h0004_0007); tick();
        n_checks++; if (err_missing_arg !== 1'b1) begin n_errors++; $display("FAIL miss_flag got=%b exp=1", err_missing_arg); end
        n_checks++; if (cmd_valid !== 1'b0)       begin n_errors++; $display("FAIL miss_valid got=%b exp=0", cmd_valid); end
        wr_op(3, 64'hC3); tick();
        ring(64'h0004_0007); tick();
        n_checks++; if (cmd_valid !== 1'b1 || cmd.seq !== 16'd0 || cmd.args[2] !== 64'hC3)
            begin n_errors++; $display("FAIL miss_seq got=%b/%h/%h exp=1/0/c3", cmd_valid, cmd.seq, cmd.args[2]); end
        n_checks++; if (err_missing_arg !== 1'b1) begin n_errors++; $display("FAIL miss_sticky got=%b exp=1", err_missing_arg); end
    endtask

    task automatic test_overflow();
        do_reset();
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ring(64'h0000_0010 + 64'(i)); tick();
        end
        n_checks++; if (cmd_count !== 3'd4)    begin n_errors++; $display("FAIL ovf_count got=%0d exp=4", cmd_count); end
        n_checks++; if (err_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (cmd_valid !== 1'b1 || cmd.seq !== 16'(k) || cmd.opcode !== 16'(16 + k))
                begin n_errors++; $display("FAIL ovf_drain%0d got=%b/%h/%h exp=1/%h/%h", k, cmd_valid, cmd.seq, cmd.opcode, k, 16 + k); end
            tick();
        end
        n_checks++; if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_empty got=%b exp=0", cmd_valid); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin ring(64'h0000_0020); tick(); end
        cmd_ready = 1'b1;
        ring(64'h0000_0021); tick();
        cmd_ready = 1'b0;
        n_checks++; if (cmd_count !== 3'd4 || err_overflow !== 1'b0)
            begin n_errors++; $display("FAIL fullpop got=%0d/%b exp=4/0", cmd_count, err_overflow); end
        n_checks++; if (cmd.seq !== 16'd1) begin n_errors++; $display("FAIL fullpop_head got=%h exp=1", cmd.seq); end
    endtask

    task automatic test_bypass();
        do_reset();
        wr_op(1, 64'h1111); tick();
        wr_op(1, 64'hDEAD_BEEF_0000_2222);
        ring(64'h0001_0009); tick();
        n_checks++; if (cmd.args[0] !== 64'hDEAD_BEEF_0000_2222 || cmd.opcode !== 16'd9)
            begin n_errors++; $display("FAIL bypass got=%h/%h exp=deadbeef00002222/9", cmd.args[0], cmd.opcode); end
        ring(64'h0001_000A); tick();
        n_checks++; if (err_missing_arg !== 1'b1 || cmd_count !== 3'd1)
            begin n_errors++; $display("FAIL bypass_clear got=%b/%0d exp=1/1", err_missing_arg, cmd_count); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin ring(64'h0000_0030); tick(); end
        ring(64'h0004_0031); tick();
        n_checks++; if (cmd_count !== 3'd3 || err_missing_arg !== 1'b1)
            begin n_errors++; $display("FAIL preflush got=%0d/%b exp=3/1", cmd_count, err_missing_arg); end
        ring(64'h0000_FFFF); tick();
        n_checks++; if (cmd_count !== 3'd0 || cmd_valid !== 1'b0 || err_missing_arg !== 1'b0 || err_overflow !== 1'b0)
            begin n_errors++; $display("FAIL flush got=%0d/%b/%b/%b exp=0/0/0/0", cmd_count, cmd_valid, err_missing_arg, err_overflow); end
        ring(64'h0000_0032); tick();
        n_checks++; if (cmd_valid !== 1'b1 || cmd.seq !== 16'd3)
            begin n_errors++; $display("FAIL flush_seq got=%b/%h exp=1/3", cmd_valid, cmd.seq); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ring(64'h0000_0040); tick();
        ring(64'h0000_0041); tick();
        wr_op(1, 64'h77); tick();
        reset = 1'b1; tick();
        n_checks++; if (cmd !== '0 || cmd_valid !== 1'b0)
            begin n_errors++; $display("FAIL midreset got=%b/%h exp=0/0", cmd_valid, cmd); end
        reset = 1'b0; tick();
        n_checks++; if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_after got=%b exp=0", cmd_valid); end
        ring(64'h0001_0042); tick();
        n_checks++; if (err_missing_arg !== 1'b1 || cmd_count !== 3'd0)
            begin n_errors++; $display("FAIL midreset_operand got=%b/%0d exp=1/0", err_missing_arg, cmd_count); end
    endtask

    task automatic test_random();
        int p_ready;
        logic [15:0] op;
        do_reset();
        p_ready = 50;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 50 == 0) p_ready = $urandom_range(0, 100);
            cmd_ready = ($urandom_range(0, 99) < p_ready);
            for (int i = 1; i < 4; i++)
                if ($urandom_range(0, 2) == 0) wr_op(i, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) begin
                op = 16'($urandom);
                if ($urandom_range(0, 19) == 0) op = 16'hFFFF;
                else if (op == 16'hFFFF) op = 16'hFFFE;
                ring({32'($urandom) & 32'hFFF8_0000 | (32'($urandom_range(0, 7)) << 16), 16'h0, op});
            end
            tick();
            n_checks++; if (cmd_valid !== (m_q.size() != 0) || cmd_count !== 3'(m_q.size()))
                begin n_errors++; $display("FAIL rnd_occ cyc=%0d got=%b/%0d exp=%0d", cyc, cmd_valid, cmd_count, m_q.size()); end
            n_checks++; if (err_missing_arg !== m_errm || err_overflow !== m_erro)
                begin n_errors++; $display("FAIL rnd_err cyc=%0d got=%b%b exp=%b%b", cyc, err_missing_arg, err_overflow, m_errm, m_erro); end
            if (m_q.size() != 0) begin
                n_checks++; if (cmd !== m_q[0])
                    begin n_errors++; $display("FAIL rnd_cmd cyc=%0d got=%h/%h exp=%h/%h", cyc, cmd.opcode, cmd.seq, m_q[0].opcode, m_q[0].seq); end
            end
        end
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_ready = 1'b0;
        wr_csrs   = '0;
        m_q.delete();
        m_present = '0;
        foreach (m_args[i]) m_args[i] = '0;
        m_seq = '0; m_errm = 0; m_erro = 0;
        test_reset();
        test_basic();
        test_missing();
        test_overflow();
        test_full_pop();
        test_bypass();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
